// File: rtl/dec_seq_pkg.sv
// ---------------------------------------------------------------------------
// dec_seq_pkg
// Shared constants and helpers for the dec_seq strobe/row-select sequencer.
//   mode_e  : MODE_DIRECT (registered decode of `in`) / MODE_SCAN (stepping).
//   MAX_N   : widest index the onehot() helper supports.
//   onehot(): returns a one-hot vector with bit `i` set (MAX_N-bit index,
//             2^MAX_N-bit result). Callers narrow it to 2^N bits.
// ---------------------------------------------------------------------------
package dec_seq_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int MAX_N = 8;

    function automatic logic [2**MAX_N-1:0] onehot(input logic [MAX_N-1:0] i);
        logic [2**MAX_N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_seq_if.sv
// ---------------------------------------------------------------------------
// dec_seq_if
// Control/select bundle between a controller (master) and dec_seq (slave).
//   en     : output enable (0 forces out to zero, pauses the scan)
//   mode   : 0 = direct decode, 1 = scan
//   in     : direct index / scan load value (N bits)
//   load   : scan mode: load `in` into the index
//   dwell  : scan mode: cycles per step minus one (DW bits)
//   dir    : scan direction, 1 = descending (only with DEC_SEQ_DIR_EN)
//   out    : registered one-hot select (2^N bits)
//   idx    : current index register (N bits)
//   wrap   : one-cycle pulse when the scan index wraps
// Optional macro: DEC_SEQ_DIR_EN adds the `dir` signal.
// ---------------------------------------------------------------------------
interface dec_seq_if #(
    parameter int N  = 3,
    parameter int DW = 4
);
    logic           en;
    logic           mode;
    logic [N-1:0]   in;
    logic           load;
    logic [DW-1:0]  dwell;
`ifdef DEC_SEQ_DIR_EN
    logic           dir;
`endif
    logic [2**N-1:0] out;
    logic [N-1:0]    idx;
    logic            wrap;

    modport master (
        output en, mode, in, load, dwell,
`ifdef DEC_SEQ_DIR_EN
        output dir,
`endif
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, in, load, dwell,
`ifdef DEC_SEQ_DIR_EN
        input  dir,
`endif
        output out, idx, wrap
    );
endinterface

// File: rtl/dec_seq_dwell_cnt.sv
// ---------------------------------------------------------------------------
// dec_seq_dwell_cnt
// Dwell counter for the scan sequencer. Counts enabled cycles spent on the
// current index and raises `step` (combinational) on the cycle the index
// must advance.
//   clk, rst_n : clock, asynchronous active-low reset
//   scan       : 1 when the sequencer is in scan mode
//   en         : enable; 0 freezes the count (scan pause)
//   load       : index reload; restarts the count and suppresses the step
//   dwell      : cycles per step minus one
//   step       : advance the index at the next edge
// ---------------------------------------------------------------------------
module dec_seq_dwell_cnt #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scan,
    input  logic          en,
    input  logic          load,
    input  logic [DW-1:0] dwell,
    output logic          step
);
    logic [DW-1:0] cnt_reg;
    logic [DW-1:0] cnt_next;

    // `>=` rather than `==` so that lowering dwell below the running count
    // forces an immediate step instead of letting the counter run away.
    always_comb begin
        step     = 1'b0;
        cnt_next = cnt_reg;
        if (!scan || load) begin
            cnt_next = '0;
        end else if (en) begin
            if (cnt_reg >= dwell) begin
                step     = 1'b1;
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
    end
endmodule

// File: rtl/dec_seq.sv
// ---------------------------------------------------------------------------
// dec_seq
// N-to-2^N one-hot decoder / scan sequencer with registered output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dec_seq_if.slave (en, mode, in, load, dwell, [dir] in;
//                out, idx, wrap out)
// Direct mode registers onehot(in). Scan mode steps the index through all
// 2^N values, holding each for dwell+1 enabled cycles; load overrides.
// Optional macro: DEC_SEQ_DIR_EN enables descending scan via bus.dir.
// N must not exceed dec_seq_pkg::MAX_N.
// ---------------------------------------------------------------------------
module dec_seq
    import dec_seq_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    dec_seq_if.slave     bus
);
    localparam int OW = 1 << N;

    logic [N-1:0]  idx_reg, idx_next;
    logic [OW-1:0] out_reg, out_next;
    logic          wrap_reg, wrap_next;
    logic          scan;
    logic          step;
    logic          down;

    assign scan = (bus.mode == MODE_SCAN);

`ifdef DEC_SEQ_DIR_EN
    assign down = bus.dir;
`else
    assign down = 1'b0;
`endif

    dec_seq_dwell_cnt #(.DW(DW)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .scan  (scan),
        .en    (bus.en),
        .load  (bus.load),
        .dwell (bus.dwell),
        .step  (step)
    );

    always_comb begin
        idx_next  = idx_reg;
        wrap_next = 1'b0;
        if (!scan || bus.load) begin
            idx_next = bus.in;
        end else if (step) begin
            if (down) begin
                idx_next  = idx_reg - N'(1);
                wrap_next = (idx_reg == '0);
            end else begin
                idx_next  = idx_reg + N'(1);
                wrap_next = &idx_reg;
            end
        end
        // Decode the next index, so out always matches idx after the edge.
        out_next = bus.en ? OW'(onehot(MAX_N'(idx_next))) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg  <= '0;
            out_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            idx_reg  <= idx_next;
            out_reg  <= out_next;
            wrap_reg <= wrap_next;
        end
    end

    assign bus.out  = out_reg;
    assign bus.idx  = idx_reg;
    assign bus.wrap = wrap_reg;
endmodule

// File: tb/tb_dec_seq.sv
// ---------------------------------------------------------------------------
// tb_dec_seq
// Self-checking bench for dec_seq (N=3, DW=4). Directed steps followed by a
// randomized phase; every cycle is compared against a behavioural model.
// Optional macro: DEC_SEQ_DIR_EN adds descending-scan steps.
// ---------------------------------------------------------------------------
module tb_dec_seq;
    localparam int N  = 3;
    localparam int DW = 4;
    localparam int OW = 1 << N;
    localparam int M  = 1 << N;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dec_seq_if #(.N(N), .DW(DW)) bus ();

    dec_seq #(.N(N), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic dir_v = 1'b0;
`ifdef DEC_SEQ_DIR_EN
    assign bus.dir = dir_v;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model state: index, enabled cycles already spent on it, wrap pulse.
    int            m_idx  = 0;
    int            m_cnt  = 0;
    logic          m_wrap = 1'b0;
    logic [OW-1:0] m_out  = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, " out"},  32'(bus.out),  32'(m_out));
        chk({where, " idx"},  32'(bus.idx),  32'(m_idx));
        chk({where, " wrap"}, 32'(bus.wrap), 32'(m_wrap));
    endtask

    task automatic model_reset();
        m_idx  = 0;
        m_cnt  = 0;
        m_wrap = 1'b0;
        m_out  = '0;
    endtask

    // One clock edge of the sequencer, evaluated from the rules directly.
    task automatic model_edge();
        m_wrap = 1'b0;
        if (!bus.mode) begin
            m_idx = int'(bus.in);
            m_cnt = 0;
        end else if (bus.load) begin
            m_idx = int'(bus.in);
            m_cnt = 0;
        end else if (!bus.en) begin
            // paused: index and elapsed count hold
        end else if (m_cnt >= int'(bus.dwell)) begin
            m_cnt = 0;
            if (dir_v) begin
                m_wrap = (m_idx == 0);
                m_idx  = (m_idx + M - 1) % M;
            end else begin
                m_wrap = (m_idx == M - 1);
                m_idx  = (m_idx + 1) % M;
            end
        end else begin
            m_cnt = m_cnt + 1;
        end
        m_out = '0;
        if (bus.en) m_out[m_idx] = 1'b1;
    endtask

    task automatic cyc(input string where);
        @(posedge clk);
        model_edge();
        #1;
        check_all(where);
    endtask

    task automatic drive(input logic en, input logic mode, input int in,
                         input logic load, input int dwell);
        bus.en    = en;
        bus.mode  = mode;
        bus.in    = N'(in);
        bus.load  = load;
        bus.dwell = DW'(dwell);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic hard_reset(input string where);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all({where, " rst-now"});
        repeat (2) @(posedge clk);
        #1;
        check_all({where, " rst-hold"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wraps;
        drive(1'b0, 1'b0, 0, 1'b0, 0);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Direct sweep, enabled then disabled
        for (int i = 0; i < M; i++) begin
            drive(1'b1, 1'b0, i, 1'b0, 0);
            cyc("direct-en");
            chk("direct-en onehot", 32'(bus.out), 32'(1) << i);
        end
        for (int i = 0; i < M; i++) begin
            drive(1'b0, 1'b0, i, 1'b0, 0);
            cyc("direct-dis");
        end

        // Scan dwell=0 from reset: one step per cycle, single wrap pulse
        hard_reset("pre-scan0");
        drive(1'b1, 1'b1, 0, 1'b0, 0);
        wraps = 0;
        for (int i = 1; i <= M; i++) begin
            cyc("scan0");
            if (bus.wrap === 1'b1) wraps++;
        end
        chk("scan0 wrap-count", 32'(wraps), 32'd1);
        chk("scan0 wrap-out", 32'(bus.out), 32'd1);

        // Scan dwell=2 with a 4-cycle enable drop mid-hold
        drive(1'b1, 1'b1, 0, 1'b0, 2);
        repeat (7) cyc("scan2");
        drive(1'b0, 1'b1, 0, 1'b0, 2);
        repeat (4) cyc("scan2-pause");
        drive(1'b1, 1'b1, 0, 1'b0, 2);
        repeat (8) cyc("scan2-resume");

        // Load collides with a due step: load wins, next step dwell+1 later
        drive(1'b1, 1'b1, 1, 1'b1, 2);
        cyc("load1");
        drive(1'b1, 1'b1, 1, 1'b0, 2);
        repeat (2) cyc("load1-count");
        drive(1'b1, 1'b1, 5, 1'b1, 2);
        cyc("load5");
        chk("load5 idx", 32'(bus.idx), 32'd5);
        drive(1'b1, 1'b1, 0, 1'b0, 2);
        repeat (2) cyc("load5-hold");
        chk("load5 still", 32'(bus.idx), 32'd5);
        cyc("load5-step");
        chk("load5 step6", 32'(bus.idx), 32'd6);

        // idx=3, cnt=5, dwell 7 -> 2 steps on the next edge
        drive(1'b1, 1'b1, 3, 1'b1, 7);
        cyc("dw-load3");
        drive(1'b1, 1'b1, 3, 1'b0, 7);
        repeat (5) cyc("dw-count");
        chk("dw idx3", 32'(bus.idx), 32'd3);
        drive(1'b1, 1'b1, 3, 1'b0, 2);
        cyc("dw-lower");
        chk("dw step4", 32'(bus.idx), 32'd4);

`ifdef DEC_SEQ_DIR_EN
        // Descending scan from 0: 7,6,... with wrap on the 0->7 step
        hard_reset("pre-down");
        dir_v = 1'b1;
        drive(1'b1, 1'b1, 0, 1'b0, 0);
        cyc("down-first");
        chk("down first idx", 32'(bus.idx), 32'd7);
        chk("down first wrap", 32'(bus.wrap), 32'd1);
        repeat (M) cyc("down");
        dir_v = 1'b0;
`endif

        // Randomized phase with occasional asynchronous resets
        for (int t = 0; t < 400; t++) begin
            drive(($urandom % 8) != 0, ($urandom % 6) != 0,
                  int'($urandom % M), ($urandom % 12) == 0,
                  int'($urandom % 4));
`ifdef DEC_SEQ_DIR_EN
            if (($urandom % 5) == 0) dir_v = ~dir_v;
`endif
            cyc("rand");
            if ((t % 97) == 96) hard_reset("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dec_seq.md
Name: dec_seq

Overview:
- Parametrised N-to-2^N one-hot decoder with a registered output and an enable, the generalised successor of the 3-to-8 decoder.
- Two modes:
  - direct: registered decode of `in`.
  - scan: an internal index steps through all 2^N outputs, holding each for a programmable dwell time.
- Used as a strobe/row-select sequencer feeding downstream select lines.

Parameters:
- N, 3: index width; output width is 2^N.
- DW, 4: width of the dwell-count input and internal dwell counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  output enable; 0 forces `out` to all-zero.
- mode  input  1  0 = direct decode, 1 = scan.
- in  input  N  direct-mode index; also the scan-mode load value.
- load  input  1  scan mode: load `in` into the index.
- dwell  input  DW  scan mode: cycles per step minus one.
- out  output  2^N  registered one-hot (or zero) select.
- idx  output  N  current index register.
- wrap  output  1  one-cycle pulse when the scan index wraps from 2^N-1 to 0.

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - Reset `rst_n` is asynchronous, active-low.
  - While `rst_n`=0: `out`=0, `idx`=0, dwell counter `cnt`=0, `wrap`=0.
  - Reset mid-scan abandons the scan. The first cycle after release behaves as a fresh start from `idx`=0.
- Output rule:
  - Every rising edge: `out` <= `en` ? (1 << `idx_next`) : 0.
  - `out` therefore always equals onehot(`idx`) or 0. It is never multi-hot.
- Direct mode (`mode`=0):
  - `idx_next` = `in`.
  - `cnt` <= 0.
  - `wrap` <= 0.
  - Latency: `in` sampled at edge k appears on `out`/`idx` after edge k (1 cycle).
  - `load` and `dwell` are ignored.
- Scan mode (`mode`=1), evaluated in priority order:
  1. `load`=1: `idx_next` = `in`, `cnt` <= 0, `wrap` <= 0. Load beats a pending step.
  2. `en`=0: `idx` and `cnt` hold, `wrap` <= 0. The scan pauses and resumes where it stopped.
  3. `cnt` >= `dwell`: `idx_next` = `idx`+1 mod 2^N, `cnt` <= 0. `wrap` <= 1 iff `idx` = 2^N-1.
  4. Otherwise: `idx` holds, `cnt` <= `cnt`+1, `wrap` <= 0.
- Dwell timing:
  - Each index is held for `dwell`+1 enabled cycles.
  - `dwell`=0 steps every cycle.
  - The `>=` compare means lowering `dwell` below the current `cnt` steps on the next edge. The counter never runs away.
- Mode switch:
  - 0->1: the scan starts from the current `idx` with `cnt` cleared (`cnt` is already 0 from direct mode).
  - 1->0: takes `in` on the next edge.
- Width rules:
  - `idx` arithmetic is modulo 2^N.
  - `cnt` is DW bits and never exceeds `dwell`.

Optional Feature:
- Macro: DEC_SEQ_DIR_EN.
- Defined:
  - Adds input port `dir` (1 bit).
  - `dir`=1 makes the scan step `idx`-1 mod 2^N.
  - `wrap` pulses on the 0 -> 2^N-1 transition when decrementing.
  - `dir` is sampled at each step. Changing it mid-dwell affects only the next step.
- Undefined:
  - No `dir` port.
  - Scan is always ascending.

Decomposition:
- Package `dec_seq_pkg`:
  - `MODE_DIRECT`/`MODE_SCAN` constants.
  - Function `onehot(idx)` returning 2^N bits.
- Natural sub-module: `dec_seq_dwell_cnt`, the dwell counter producing a `step` strobe from `cnt`, `dwell`, `en`, `load`.
- The top module holds the index register, decode and wrap logic.

Test Plan:
- Direct sweep, N=3, en=1, mode=0, `in`=0..7 one per cycle -> `out`=00000001..10000000 one cycle later, `idx`=`in`. Repeat with en=0 -> `out`=00000000.
- Scan, dwell=0, mode=1 from reset -> `idx` 0,1,..,7,0 on consecutive cycles. `wrap`=1 only on the 7->0 cycle; `out`=00000001 that cycle.
- Scan, dwell=2 -> each `out` value held exactly 3 cycles. Drop `en` for 4 cycles mid-hold -> `out`=0 for those cycles, then the same index resumes with its remaining hold count.
- Scan with `load`=1, `in`=5 on the same cycle a step is due -> `idx`=5, `cnt`=0 (load wins). Next step to 6 occurs `dwell`+1 cycles later.
- Scan at `idx`=3, `cnt`=5, `dwell` changed 7->2 -> step to 4 on the next edge.
- Assert `rst_n`=0 asynchronously mid-cycle -> `out`, `idx`, `wrap` clear immediately.
- With DEC_SEQ_DIR_EN, `dir`=1, dwell=0 from `idx`=0 -> `idx` 7,6,...; `wrap`=1 on the 0->7 step.
